// File: rtl/wave_pkg.sv
// Shared constants for the wave shaper: mode encodings, DAC midscale and the
// quarter-wave sine magnitude table L[k] = round(127*sin(2*pi*(k+0.5)/256)).
package wave_pkg;

  localparam logic [1:0] MODE_SAW = 2'b00;
  localparam logic [1:0] MODE_TRI = 2'b01;
  localparam logic [1:0] MODE_SQR = 2'b10;
  localparam logic [1:0] MODE_SIN = 2'b11;

  localparam logic [7:0] MIDSCALE = 8'h80;

  function automatic logic [6:0] quarter_sine(input logic [5:0] k);
    logic [6:0] m;
    case (k)
      6'd0:  m = 7'd2;   6'd1:  m = 7'd5;   6'd2:  m = 7'd8;   6'd3:  m = 7'd11;
      6'd4:  m = 7'd14;  6'd5:  m = 7'd17;  6'd6:  m = 7'd20;  6'd7:  m = 7'd23;
      6'd8:  m = 7'd26;  6'd9:  m = 7'd29;  6'd10: m = 7'd32;  6'd11: m = 7'd35;
      6'd12: m = 7'd38;  6'd13: m = 7'd41;  6'd14: m = 7'd44;  6'd15: m = 7'd47;
      6'd16: m = 7'd50;  6'd17: m = 7'd53;  6'd18: m = 7'd56;  6'd19: m = 7'd58;
      6'd20: m = 7'd61;  6'd21: m = 7'd64;  6'd22: m = 7'd67;  6'd23: m = 7'd69;
      6'd24: m = 7'd72;  6'd25: m = 7'd74;  6'd26: m = 7'd77;  6'd27: m = 7'd79;
      6'd28: m = 7'd82;  6'd29: m = 7'd84;  6'd30: m = 7'd86;  6'd31: m = 7'd89;
      6'd32: m = 7'd91;  6'd33: m = 7'd93;  6'd34: m = 7'd95;  6'd35: m = 7'd97;
      6'd36: m = 7'd99;  6'd37: m = 7'd101; 6'd38: m = 7'd103; 6'd39: m = 7'd105;
      6'd40: m = 7'd106; 6'd41: m = 7'd108; 6'd42: m = 7'd110; 6'd43: m = 7'd111;
      6'd44: m = 7'd113; 6'd45: m = 7'd114; 6'd46: m = 7'd115; 6'd47: m = 7'd117;
      6'd48: m = 7'd118; 6'd49: m = 7'd119; 6'd50: m = 7'd120; 6'd51: m = 7'd121;
      6'd52: m = 7'd122; 6'd53: m = 7'd123; 6'd54: m = 7'd124; 6'd55: m = 7'd124;
      6'd56: m = 7'd125; 6'd57: m = 7'd125; 6'd58: m = 7'd126; 6'd59: m = 7'd126;
      default: m = 7'd127;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Combinational quarter-wave sine lookup: 6-bit index to 7-bit magnitude.
module sine_quarter_rom
  import wave_pkg::*;
(
  input  logic [5:0] idx_i,
  output logic [6:0] mag_o
);

  assign mag_o = quarter_sine(idx_i);

endmodule

// File: rtl/wave_shaper.sv
// Maps the phase-counter output onto one sample of saw/triangle/square/sine.
// Two registered stages; mode and duty only change at a phase wrap.
module wave_shaper
  import wave_pkg::*;
#(
  parameter int           W          = 8,
  parameter logic [W-1:0] RST_SAMPLE = MIDSCALE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] phase,
  input  logic         phase_valid,
  input  logic [1:0]   mode,
  input  logic [W-1:0] duty,
  output logic [W-1:0] sample,
  output logic         sample_valid,
  output logic         wrap
);

  // phase_q doubles as last_phase: both only update on a valid phase.
  logic [W-1:0] phase_q;
  logic         started_q;
  logic         s1_valid_q;
  logic         s1_wrap_q;
  logic [1:0]   mode_q;
  logic [W-1:0] duty_q;
  logic [W-1:0] sample_q;
  logic [W-1:0] sample_d;
  logic         sample_valid_q;
  logic         wrap_q;

  logic         wrap_det;
  logic         load_active;
  logic [5:0]   sin_idx;
  logic [6:0]   sin_mag;

  assign wrap_det    = started_q & (phase < phase_q);
  assign load_active = wrap_det | ~started_q;

  // NOTE: every flop here, data included, takes the async reset so a mid-stream reset is clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= '0;
      started_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_wrap_q  <= 1'b0;
      mode_q     <= MODE_SAW;
      duty_q     <= MIDSCALE;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      s1_valid_q <= phase_valid;
      s1_wrap_q  <= phase_valid & wrap_det;
      if (phase_valid) begin
        phase_q   <= phase;
        started_q <= 1'b1;
        if (load_active) begin
          mode_q <= mode;
          duty_q <= duty;
        end
      end
    end
  end

  // Quadrants 1 and 3 read the table mirrored; 63-i is just ~i on 6 bits.
  assign sin_idx = phase_q[6] ? ~phase_q[5:0] : phase_q[5:0];

  sine_quarter_rom u_sine_rom (
    .idx_i (sin_idx),
    .mag_o (sin_mag)
  );

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves sample_d unassigned (no latch).
    sample_d = phase_q;
    case (mode_q)
      MODE_TRI: sample_d = phase_q[W-1] ? ~{phase_q[W-2:0], 1'b0} : {phase_q[W-2:0], 1'b0};
      MODE_SQR: sample_d = (phase_q < duty_q) ? '1 : '0;
      // 128+L for the positive half, 127-L for the negative half.
      MODE_SIN: sample_d = {~phase_q[7], phase_q[7] ? ~sin_mag : sin_mag};
      default:  sample_d = phase_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q       <= RST_SAMPLE;
      sample_valid_q <= 1'b0;
      wrap_q         <= 1'b0;
    end else begin
      sample_valid_q <= s1_valid_q;
      wrap_q         <= s1_wrap_q;
      if (s1_valid_q) begin
        sample_q <= sample_d;
      end
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign wrap         = wrap_q;

endmodule

// File: tb/tb_wave_shaper.sv
// Scoreboard bench for wave_shaper: stimulus pushes expectations from a
// real-arithmetic reference model; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_wave_shaper;
  import wave_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] phase;
  logic       phase_valid;
  logic [1:0] mode;
  logic [7:0] duty;
  logic [7:0] sample;
  logic       sample_valid;
  logic       wrap;

  wave_shaper dut (
    .clk          (clk),
    .rst          (rst),
    .phase        (phase),
    .phase_valid  (phase_valid),
    .mode         (mode),
    .duty         (duty),
    .sample       (sample),
    .sample_valid (sample_valid),
    .wrap         (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sample;
    logic       wrap;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model state: what the shaper should be using right now.
  logic [1:0] m_mode;
  logic [7:0] m_duty;
  logic [7:0] m_last;
  bit         m_started;

  function automatic logic [7:0] ref_shape(input logic [1:0] md, input logic [7:0] d,
                                           input logic [7:0] p);
    int  pn;
    real s;
    int  r;
    pn = int'(p);
    case (md)
      MODE_SAW: return p;
      MODE_TRI: return (pn < 128) ? 8'(2 * pn) : 8'(511 - 2 * pn);
      MODE_SQR: return (p < d) ? 8'hFF : 8'h00;
      default: begin
        s = 127.0 * $sin(2.0 * 3.14159265358979 * (real'(pn) + 0.5) / 256.0);
        r = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
        return (pn < 128) ? 8'(128 + r) : 8'(127 + r);
      end
    endcase
  endfunction

  // Literal sample values for a few well-known phases.
  task automatic spot_value(input logic [1:0] md, input logic [7:0] p,
                            output bit has, output logic [7:0] v);
    has = 1'b1;
    v   = 8'h00;
    if (md == MODE_TRI && p == 8'd0)        v = 8'd0;
    else if (md == MODE_TRI && p == 8'd63)  v = 8'd126;
    else if (md == MODE_TRI && p == 8'd127) v = 8'd254;
    else if (md == MODE_TRI && p == 8'd128) v = 8'd255;
    else if (md == MODE_TRI && p == 8'd255) v = 8'd1;
    else if (md == MODE_SIN && p == 8'd0)   v = 8'd130;
    else if (md == MODE_SIN && p == 8'd64)  v = 8'd255;
    else if (md == MODE_SIN && p == 8'd128) v = 8'd125;
    else if (md == MODE_SIN && p == 8'd192) v = 8'd0;
    else has = 1'b0;
  endtask

  task automatic model_reset();
    m_mode    = MODE_SAW;
    m_duty    = MIDSCALE;
    m_last    = 8'd0;
    m_started = 1'b0;
    exp_q.delete();
  endtask

  task automatic issue(input logic [7:0] p, input logic [1:0] md, input logic [7:0] d);
    exp_t       e;
    logic       w;
    bit         has;
    logic [7:0] sp;
    w = m_started && (p < m_last);
    if (w || !m_started) begin
      m_mode = md;
      m_duty = d;
    end
    m_last    = p;
    m_started = 1'b1;
    e.sample  = ref_shape(m_mode, m_duty, p);
    spot_value(m_mode, p, has, sp);
    if (has) e.sample = sp;
    e.wrap = w;
    e.cyc  = cyc + 2;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic v, input logic [7:0] p, input logic [1:0] md,
                      input logic [7:0] d);
    @(posedge clk);
    #1;
    phase_valid = v;
    phase       = p;
    mode        = md;
    duty        = d;
    if (v) issue(p, md, d);
  endtask

  task automatic sweep(input logic [1:0] md, input logic [7:0] d);
    for (int p = 0; p < 256; p++) step(1'b1, 8'(p), md, d);
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, mode, duty);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #3;
    rst         = 1'b1;
    phase_valid = 1'b0;
    #1;
    check("rst_async_sample", 32'(sample), 32'(MIDSCALE));
    check("rst_async_valid", 32'(sample_valid), 32'd0);
    check("rst_async_wrap", 32'(wrap), 32'd0);
    model_reset();
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: reset values, scoreboard pops on valid, hold behaviour on bubbles.
  logic [7:0] held = MIDSCALE;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (rst) begin
      check("reset_sample", 32'(sample), 32'(MIDSCALE));
      check("reset_valid", 32'(sample_valid), 32'd0);
      check("reset_wrap", 32'(wrap), 32'd0);
      held = MIDSCALE;
    end else if (sample_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid_queue_depth", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("sample", 32'(sample), 32'(mon_e.sample));
        check("wrap", 32'(wrap), 32'(mon_e.wrap));
        check("latency_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
      held = sample;
    end else begin
      check("bubble_hold_sample", 32'(sample), 32'(held));
      check("bubble_wrap", 32'(wrap), 32'd0);
    end
  end

  initial begin
    logic [7:0] p;
    logic [1:0] md;
    logic [7:0] d;
    rst         = 1'b1;
    phase_valid = 1'b0;
    phase       = 8'h00;
    mode        = MODE_SAW;
    duty        = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bubbles(3);

    sweep(MODE_SAW, 8'h00);
    sweep(MODE_SAW, 8'h00);

    // Mode requested mid-period must wait for the wrap.
    for (int i = 0; i < 256; i++) step(1'b1, 8'(i), (i < 50) ? MODE_SAW : MODE_TRI, 8'h00);
    sweep(MODE_TRI, 8'h00);
    sweep(MODE_SIN, 8'h00);
    sweep(MODE_SIN, 8'h00);

    sweep(MODE_SQR, 8'd64);
    for (int i = 0; i < 256; i++) step(1'b1, 8'(i), MODE_SQR, (i < 100) ? 8'd64 : 8'd200);
    sweep(MODE_SQR, 8'd200);
    sweep(MODE_SQR, 8'd0);
    sweep(MODE_SQR, 8'd255);

    for (int i = 0; i < 90; i++) step(1'b1, 8'(i), MODE_TRI, 8'd10);
    do_reset(2);
    bubbles(4);
    for (int i = 40; i < 256; i++) step(1'b1, 8'(i), MODE_SIN, 8'd10);
    sweep(MODE_SIN, 8'd10);

    p  = 8'd0;
    md = MODE_SAW;
    d  = 8'd128;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) md = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        step(1'b0, 8'($urandom_range(0, 255)), md, d);
      end else begin
        if ($urandom_range(0, 49) == 0) p = 8'($urandom_range(0, 255));
        else p = p + 8'($urandom_range(0, 3));
        step(1'b1, p, md, d);
      end
    end

    bubbles(4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
